// File: rtl/hazard_unit_n.sv
// hazard_unit_n
// Hazard detection and forwarding control for a LANES-wide in-order pipeline,
// plus the M-stage cache miss sequencer (tag check, writeback, line fill).
//
// Ports (lane i occupies bits [i*W +: W]; lane 0 is the oldest):
//   clk, rst_n                      clock (rising edge), async active-low reset
//   rsd, rtd / rse, rte             D / E stage source register indices
//   writerege/m/w, regwritee/m/w    E/M/W destination indices and write enables
//   memtorege, branchd              E-lane load flags, D-lane branch flags
//   memreqm, hit, dirty             M-stage memory request and cache lookup result
//   multen, multready               E-lane multiplier busy handshake
//   forwarde_a/b, forwardd_a/b      operand source selects (0 = register file,
//                                   1+j E lane j, 1+LANES+j M lane j, 1+2*LANES+j W lane j)
//   stallf/d/e/m/w, flushe          pipeline stall and flush controls
//   wb_en, fill_en                  one-cycle writeback / line-fill strobes
//   stall_cnt                       saturating count of cycles with stalld high
module hazard_unit_n #(
  parameter int LANES  = 2,
  parameter int MEMLAT = 20,
  parameter int REGW   = 5,
  parameter int FW     = $clog2(3*LANES+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*REGW-1:0]   rsd,
  input  logic [LANES*REGW-1:0]   rtd,
  input  logic [LANES*REGW-1:0]   rse,
  input  logic [LANES*REGW-1:0]   rte,
  input  logic [LANES*REGW-1:0]   writerege,
  input  logic [LANES*REGW-1:0]   writeregm,
  input  logic [LANES*REGW-1:0]   writeregw,
  input  logic [LANES-1:0]        regwritee,
  input  logic [LANES-1:0]        regwritem,
  input  logic [LANES-1:0]        regwritew,
  input  logic [LANES-1:0]        memtorege,
  input  logic [LANES-1:0]        branchd,
  input  logic                    memreqm,
  input  logic                    hit,
  input  logic                    dirty,
  input  logic [LANES-1:0]        multen,
  input  logic [LANES-1:0]        multready,
  output logic [LANES*FW-1:0]     forwarde_a,
  output logic [LANES*FW-1:0]     forwarde_b,
  output logic [LANES*FW-1:0]     forwardd_a,
  output logic [LANES*FW-1:0]     forwardd_b,
  output logic                    stallf,
  output logic                    stalld,
  output logic                    stalle,
  output logic                    stallm,
  output logic                    stallw,
  output logic                    flushe,
  output logic                    wb_en,
  output logic                    fill_en,
  output logic [31:0]             stall_cnt
);

  localparam int CW = $clog2(MEMLAT+1);

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_WB, S_FILL, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          lwstall, brstall, mstall;

  // Source select for one operand. Candidates are scanned lowest priority
  // first so later hits override: W lanes, then M lanes, then the first ne
  // E lanes; within a stage the highest lane index is scanned last and wins.
  function automatic logic [FW-1:0] pick(
    input logic [REGW-1:0]       r,
    input int                    ne,
    input logic [LANES*REGW-1:0] we,
    input logic [LANES-1:0]      ee,
    input logic [LANES*REGW-1:0] wm,
    input logic [LANES-1:0]      em,
    input logic [LANES*REGW-1:0] ww,
    input logic [LANES-1:0]      ew
  );
    logic [FW-1:0] s;
    s = '0;
    for (int j = 0; j < LANES; j++)
      if (ew[j] && ww[j*REGW +: REGW] == r) s = FW'(1 + 2*LANES + j);
    for (int j = 0; j < LANES; j++)
      if (em[j] && wm[j*REGW +: REGW] == r) s = FW'(1 + LANES + j);
    for (int j = 0; j < LANES; j++)
      if (j < ne && ee[j] && we[j*REGW +: REGW] == r) s = FW'(1 + j);
    if (r == '0) s = '0;
    return s;
  endfunction

  // E operands may take results from older E lanes (j < gi); D branch
  // operands only ever read M-stage results, so E and W enables are masked.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_fwd
    assign forwarde_a[gi*FW +: FW] = pick(rse[gi*REGW +: REGW], gi, writerege, regwritee,
                                          writeregm, regwritem, writeregw, regwritew);
    assign forwarde_b[gi*FW +: FW] = pick(rte[gi*REGW +: REGW], gi, writerege, regwritee,
                                          writeregm, regwritem, writeregw, regwritew);
    assign forwardd_a[gi*FW +: FW] = pick(rsd[gi*REGW +: REGW], 0, writerege, '0,
                                          writeregm, regwritem, writeregw, '0);
    assign forwardd_b[gi*FW +: FW] = pick(rtd[gi*REGW +: REGW], 0, writerege, '0,
                                          writeregm, regwritem, writeregw, '0);
  end

  // A load in E cannot forward in time for any D-lane consumer.
  always_comb begin
    lwstall = 1'b0;
    for (int j = 0; j < LANES; j++)
      for (int k = 0; k < LANES; k++)
        if (memtorege[j] && writerege[j*REGW +: REGW] != '0 &&
            (writerege[j*REGW +: REGW] == rsd[k*REGW +: REGW] ||
             writerege[j*REGW +: REGW] == rtd[k*REGW +: REGW]))
          lwstall = 1'b1;
  end

  // Branches resolve in D: wait on any E-stage producer, and on an M-stage
  // producer while the memory stage is still stalled on its load.
  always_comb begin
    brstall = 1'b0;
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < LANES; j++) begin
        if (branchd[i] && regwritee[j] && writerege[j*REGW +: REGW] != '0 &&
            (writerege[j*REGW +: REGW] == rsd[i*REGW +: REGW] ||
             writerege[j*REGW +: REGW] == rtd[i*REGW +: REGW]))
          brstall = 1'b1;
        if (branchd[i] && regwritem[j] && stallm && writeregm[j*REGW +: REGW] != '0 &&
            (writeregm[j*REGW +: REGW] == rsd[i*REGW +: REGW] ||
             writeregm[j*REGW +: REGW] == rtd[i*REGW +: REGW]))
          brstall = 1'b1;
      end
  end

  assign mstall = |(multen & ~multready);
  assign stallm = (state_q == S_TAG) || (state_q == S_WB) || (state_q == S_FILL);
  assign stalle = stallm | mstall;
  assign stalld = lwstall | brstall | stalle;
  assign stallf = stalld;
  assign stallw = stallm;
  assign flushe = (lwstall | brstall) & ~stalle;

  // Strobes are decoded from registered state so they drop the instant
  // reset asserts and can never fire for an abandoned transfer.
  assign wb_en   = (state_q == S_WB)   && (cnt_q == CW'(1));
  assign fill_en = (state_q == S_FILL) && (cnt_q == CW'(1));
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (memreqm) state_d = S_TAG;
      S_TAG: begin
        if (!memreqm) begin
          state_d = S_IDLE;
        end else if (hit) begin
          state_d = S_DONE;
        end else begin
          state_d = dirty ? S_WB : S_FILL;
          cnt_d   = CW'(MEMLAT);
        end
      end
      S_WB: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_FILL;
          cnt_d   = CW'(MEMLAT);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FILL: begin
        // Re-run the lookup after the fill; it hits this time.
        if (cnt_q == CW'(1)) begin
          state_d = S_TAG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalld && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_n.sv
module tb_hazard_unit_n;
  localparam int LANES = 2;
  localparam int MEMLAT = 20;
  localparam int REGW = 5;
  localparam int FW = 3;

  logic clk, rst_n;
  logic [LANES*REGW-1:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
  logic [LANES-1:0] regwritee, regwritem, regwritew, memtorege, branchd, multen, multready;
  logic memreqm, hit, dirty;
  logic [LANES*FW-1:0] forwarde_a, forwarde_b, forwardd_a, forwardd_b;
  logic stallf, stalld, stalle, stallm, stallw, flushe, wb_en, fill_en;
  logic [31:0] stall_cnt;

  hazard_unit_n #(.LANES(LANES), .MEMLAT(MEMLAT), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
    .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
    .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
    .memtorege(memtorege), .branchd(branchd),
    .memreqm(memreqm), .hit(hit), .dirty(dirty),
    .multen(multen), .multready(multready),
    .forwarde_a(forwarde_a), .forwarde_b(forwarde_b),
    .forwardd_a(forwardd_a), .forwardd_b(forwardd_b),
    .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
    .stallw(stallw), .flushe(flushe), .wb_en(wb_en), .fill_en(fill_en),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic clear_inputs();
    rsd = '0; rtd = '0; rse = '0; rte = '0;
    writerege = '0; writeregm = '0; writeregw = '0;
    regwritee = '0; regwritem = '0; regwritew = '0;
    memtorege = '0; branchd = '0; multen = '0; multready = '0;
    memreqm = 1'b0; hit = 1'b0; dirty = 1'b0;
  endtask

  // two lanes packed: {lane1, lane0}
  function automatic logic [31:0] fv(input int l1, input int l0);
    return 32'((l1 << FW) | l0);
  endfunction

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #3;
    push("rst_stallm", 0);    check(32'(stallm));
    push("rst_wb_en", 0);     check(32'(wb_en));
    push("rst_fill_en", 0);   check(32'(fill_en));
    push("rst_stall_cnt", 0); check(stall_cnt);
    push("rst_stalld", 0);    check(32'(stalld));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // load-use stall, also counted by stall_cnt over three edges
    @(negedge clk);
    memtorege = 2'b01; writerege[0 +: REGW] = 5'd7; rtd[REGW +: REGW] = 5'd7;
    #1;
    push("lw_stalld", 1); check(32'(stalld));
    push("lw_stallf", 1); check(32'(stallf));
    push("lw_flushe", 1); check(32'(flushe));
    push("lw_stalle", 0); check(32'(stalle));
    repeat (3) @(posedge clk);
    #1;
    push("cnt_after3", 3); check(stall_cnt);
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    push("cnt_hold", 3); check(stall_cnt);
    memtorege = 2'b01; #1;
    push("lw_reg0_stalld", 0); check(32'(stalld));
    clear_inputs();

    // E lane0 beats M lane1 for lane1 operand a
    rse[REGW +: REGW] = 5'd3; writerege[0 +: REGW] = 5'd3; regwritee = 2'b01;
    writeregm[REGW +: REGW] = 5'd3; regwritem = 2'b10;
    #1; push("fwd_e_wins", fv(1, 0)); check(32'(forwarde_a));
    // without the E producer both lanes pick M lane1
    regwritee = '0; rse[0 +: REGW] = 5'd3; writeregw[0 +: REGW] = 5'd3; regwritew = 2'b01;
    #1; push("fwd_m_over_w", fv(4, 4)); check(32'(forwarde_a));
    // register 0 never forwards
    rse = '0; writeregm = '0;
    #1; push("fwd_r0", fv(0, 0)); check(32'(forwarde_a));
    clear_inputs();
    // W highest lane wins; lane1 sees E lane0, lane0 cannot
    rte[0 +: REGW] = 5'd9; rte[REGW +: REGW] = 5'd9;
    writeregw[0 +: REGW] = 5'd9; writeregw[REGW +: REGW] = 5'd9; regwritew = 2'b11;
    writerege[0 +: REGW] = 5'd9; regwritee = 2'b01;
    #1; push("fwd_b_mix", fv(1, 6)); check(32'(forwarde_b));
    // D selects ignore E and W producers
    rtd[0 +: REGW] = 5'd9;
    #1; push("fwdd_b_no_ew", fv(0, 0)); check(32'(forwardd_b));
    clear_inputs();
    rsd[0 +: REGW] = 5'd4; writeregm[0 +: REGW] = 5'd4; regwritem = 2'b01;
    writerege[0 +: REGW] = 5'd4; regwritee = 2'b01;
    #1; push("fwdd_a_m0", fv(0, 3)); check(32'(forwardd_a));
    clear_inputs();

    // branch waits on an E producer
    branchd = 2'b10; rsd[REGW +: REGW] = 5'd5;
    writerege[REGW +: REGW] = 5'd5; regwritee = 2'b10;
    #1;
    push("br_e_stalld", 1); check(32'(stalld));
    push("br_e_flushe", 1); check(32'(flushe));
    // M producer alone does not stall while the M stage is idle
    regwritee = '0; writeregm[0 +: REGW] = 5'd5; regwritem = 2'b01;
    #1;
    push("br_m_idle_stalld", 0); check(32'(stalld));
    push("br_m_fwdd", fv(3, 0)); check(32'(forwardd_a));

    // multiply busy
    multen = 2'b01;
    #1;
    push("mul_stalle", 1); check(32'(stalle));
    push("mul_stalld", 1); check(32'(stalld));
    push("mul_flushe", 0); check(32'(flushe));
    push("mul_stallm", 0); check(32'(stallm));
    multready = 2'b01;
    #1; push("mul_ready_stalle", 0); check(32'(stalle));
    multen = '0; multready = '0;

    // dirty miss: TAG, 20 WB, 20 FILL, TAG, DONE; branch config kept so
    // stalld tracks stallm and flushe stays low
    @(negedge clk);
    memreqm = 1'b1; hit = 1'b0; dirty = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(posedge clk); #1;
      memreqm = (c < 5) || (c >= 40 && c <= 42);
      hit = (c >= 41);
      push($sformatf("miss_stallm_c%0d", c), 32'(c <= 42));
      push($sformatf("miss_wb_c%0d", c), 32'(c == 21));
      push($sformatf("miss_fill_c%0d", c), 32'(c == 41));
      push($sformatf("miss_stalld_c%0d", c), 32'(c <= 42));
      push($sformatf("miss_flushe_c%0d", c), 0);
      push($sformatf("miss_stallw_c%0d", c), 32'(c <= 42));
      @(negedge clk);
      check(32'(stallm)); check(32'(wb_en)); check(32'(fill_en));
      check(32'(stalld)); check(32'(flushe)); check(32'(stallw));
    end
    clear_inputs();

    // hit: single stall cycle, no strobes
    @(negedge clk);
    memreqm = 1'b1; hit = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      memreqm = (c < 2);
      push($sformatf("hit_stallm_c%0d", c), 32'(c == 1));
      push($sformatf("hit_strobes_c%0d", c), 0);
      @(negedge clk);
      check(32'(stallm)); check(32'({wb_en, fill_en}));
    end
    clear_inputs();

    // clean miss, reset asserted in FILL with cnt=5
    @(negedge clk);
    memreqm = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      memreqm = (c < 2);
    end
    push("fill_busy_stallm", 1); check(32'(stallm));
    #2 rst_n = 1'b0;
    #1;
    push("rstfill_stallm", 0);    check(32'(stallm));
    push("rstfill_fill_en", 0);   check(32'(fill_en));
    push("rstfill_stall_cnt", 0); check(stall_cnt);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      push($sformatf("post_rst_c%0d", c), 0);
      check(32'({stallm, wb_en, fill_en}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_unit_n.md
HAZARD_UNIT_N -- requirements
Module: hazard_unit_n

Interface
REQ-001 SHALL have parameters: LANES, default 2, issue width; MEMLAT, default 20, main-memory cycles per transfer (>=2); REGW, default 5, register index width; FW = $clog2(3*LANES+1), derived.
REQ-002 SHALL have ports (lane i occupies bits [i*W +: W]; lane 0 oldest):
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rsd, rtd, rse, rte  in  LANES*REGW  D/E source registers
writerege, writeregm, writeregw  in  LANES*REGW  E/M/W destination registers
regwritee, regwritem, regwritew  in  LANES  destination write enables
memtorege, branchd  in  LANES  E load, D branch
memreqm  in  1  any M-lane load/store active
hit, dirty  in  1  cache lookup result, valid one cycle after memreqm rises
multen, multready  in  LANES  E multiply busy handshake
forwarde_a, forwarde_b  out  LANES*FW  E operand source selects
forwardd_a, forwardd_b  out  LANES*FW  D branch-compare source selects
stallf, stalld, stalle, stallm, stallw, flushe  out  1  pipeline controls
wb_en, fill_en  out  1  one-cycle cache writeback / line-fill strobes
stall_cnt  out  32  saturating count of stalld cycles

Function
REQ-003 Forward select codes SHALL be: 0 register file; 1+j E lane j; 1+LANES+j M lane j; 1+2*LANES+j W lane j.
REQ-004 E select for lane i operand r (r!=0) SHALL pick first match of: E lanes j<i, highest j first; M lanes, highest j first; W lanes, highest j first; match = equal index and write enable set.
REQ-005 Register 0 SHALL never forward (code 0).
REQ-006 D selects SHALL consider M lanes only, same priority; E/W matches yield 0.
REQ-007 Load-use stall: lwstall SHALL be 1 when any E lane j has memtorege and writerege==rsd or rtd of any D lane, index !=0.
REQ-008 Branch stall: brstall SHALL be 1 when D lane i has branchd and any E lane with regwritee writes rsd/rtd of lane i (!=0), or any M lane with memtorege... replaced: any M lane load (regwritem) writes it while stallm=1.
REQ-009 Multiply stall: mstall = OR over lanes of multen & !multready.
REQ-010 Combinational: stalle=stallm|mstall; stalld=lwstall|brstall|stalle; stallf=stalld; stallw=stallm; flushe=(lwstall|brstall)&!stalle.
REQ-011 Memory FSM states IDLE, TAG, WB, FILL, DONE; counter cnt, $clog2(MEMLAT+1) bits.
REQ-012 IDLE->TAG when memreqm=1; TAG: hit=1 ->DONE; hit=0,dirty=1 ->WB, cnt=MEMLAT; hit=0,dirty=0 ->FILL, cnt=MEMLAT.
REQ-013 WB: cnt decrements each cycle; at cnt==1 SHALL pulse wb_en and go FILL with cnt=MEMLAT.
REQ-014 FILL: cnt decrements; at cnt==1 SHALL pulse fill_en and go TAG (re-lookup, now hits).
REQ-015 DONE ->IDLE unconditionally; stallm SHALL be 1 in TAG, WB, FILL, 0 in IDLE and DONE.
REQ-016 memreqm dropping mid-WB/FILL SHALL NOT abort the transfer; in TAG with memreqm=0 FSM SHALL return to IDLE.
REQ-017 stall_cnt SHALL increment on each clk with stalld=1, holding at 2^32-1.

Reset
REQ-018 rst_n=0 SHALL immediately force FSM=IDLE, cnt=0, wb_en=fill_en=0, stall_cnt=0, stallm=0; forward selects follow inputs.
REQ-019 Reset asserted mid-WB/FILL SHALL abandon the transfer with no strobe.

Verification
REQ-020 Lane1 rse=3, lane0 writerege=3, regwritee[0]=1, M lane1 also writes 3 -> forwarde_a[lane1]=1 (E lane0 wins).
REQ-021 rse=0 with matching writeregm, regwritem=1 -> forwarde_a=0.
REQ-022 memtorege[0]=1, writerege=7, rtd lane1=7 -> stalld=stallf=flushe=1, stalle=0.
REQ-023 memreqm=1, hit=0, dirty=1, MEMLAT=20 -> stallm high 1+20+20+1=42 cycles, wb_en at cycle 21, fill_en at cycle 41, DONE at 43.
REQ-024 memreqm=1, hit=1 -> stallm exactly 1 cycle, no strobes.
REQ-025 rst_n low during FILL cnt=5 -> stallm=0 same cycle, no fill_en, stall_cnt=0.
